io_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter; a responder on the refemv core's IO bus (IO space = mem_addr[22]=1).

---
 rtl/refemv_io_pkg.sv | 31 +++
 rtl/io_uart_tx_fifo.sv | 72 +++++++
 rtl/io_uart_tx.sv | 243 ++++++++++++++++++++++++
 tb/tb_io_uart_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/refemv_io_pkg.sv
// refemv_io_pkg: definitions shared by the refemv IO-space responders.
//  - tx_state_t    : transmitter FSM encoding (IDLE/START/DATA/PARITY/STOP)
//  - ST_*          : bit positions inside the UART_STATUS word
//  - IO_SEL_BIT    : mem_addr bit that selects IO space (shared with soc and LED decode)
//  - even_parity() : even parity of one transmitted byte
package refemv_io_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVR       = 3;
    localparam int ST_PAR       = 4;
    localparam int ST_COUNT_LSB = 16;

    localparam int IO_SEL_BIT   = 22;

    // XOR of all bits: 1 when the byte has an odd number of ones, which
    // makes the total count of ones in data+parity even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/io_uart_tx_fifo.sv
// uart_tx_fifo: byte-wide TX FIFO with registered storage and a combinational head.
//  Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_push     : push i_din (ignored when full at the start of the cycle)
//   i_din      : byte to store
//   i_pop      : drop the head entry (ignored when empty)
//   o_head     : current head entry (valid when !o_empty)
//   o_full     : count == DEPTH
//   o_empty    : count == 0
//   o_count    : number of stored entries, clog2(DEPTH)+1 bits
//  A pop in the same cycle as a push on a full FIFO does not make room: the
//  full flag is evaluated on the count at the start of the cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [7:0]               i_din,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers (power-of-two depth, so they wrap naturally) and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped UART transmitter on the refemv IO bus (mem_addr[22]=1).
//  The core writes bytes to UART_DATA; they queue in a TX FIFO and a baud-timed
//  shifter sends them as 8N1 frames on txd, LSB first. UART_STATUS reports
//  {count, ..., parity-present, overrun, empty, full, busy} for polling.
//  Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset (aborts any frame, txd high)
//   mem_addr   : core byte address; IO space when bit 22 is set
//   mem_wdata  : write data, byte sent = mem_wdata[7:0]
//   mem_wmask  : byte write mask; any set bit is a write
//   mem_rstrb  : read strobe
//   io_rdata   : registered read data, 1-cycle latency
//   txd        : serial output, idles high, driven from a flop
//  Build option: define UART_TX_PARITY_EN to add an even-parity bit between
//  the data bits and the stop bit (11 bit-times per frame, status bit 4 = 1).
module io_uart_tx
    import refemv_io_pkg::*;
#(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BIT   = 1,
    parameter int STATUS_BIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] io_rdata,
    output logic        txd
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] DIV_M1 = BW'(DIV - 1);

    tx_state_t     r_state;
    tx_state_t     w_state_nxt;
    logic [BW-1:0] r_baud;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    r_shreg;
    logic [7:0]    w_shreg_nxt;
    logic          r_txd;
    logic          w_txd_nxt;
    logic          w_pop;
    logic          w_bit_done;
    logic          r_ovr;
    logic [31:0]   r_rdata;
    logic [31:0]   w_status;
    logic          w_wr_data;
    logic          w_rd_stat;
    logic          w_rd_any;
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_unused;
`ifdef UART_TX_PARITY_EN
    logic          r_par;
`endif

    assign w_wr_data  = mem_addr[IO_SEL_BIT] & mem_addr[2+DATA_BIT] & (|mem_wmask);
    assign w_rd_stat  = mem_addr[IO_SEL_BIT] & mem_addr[2+STATUS_BIT] & mem_rstrb;
    assign w_rd_any   = mem_addr[IO_SEL_BIT] & mem_rstrb;
    assign w_bit_done = (r_baud == {BW{1'b0}});
    assign w_unused   = ^{mem_addr, mem_wdata[31:8]};
    assign io_rdata   = r_rdata;
    assign txd        = r_txd;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_wr_data),
        .i_din   (mem_wdata[7:0]),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; every non-idle state lasts until the baud counter hits zero.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) w_state_nxt = S_START;
                else          w_state_nxt = S_IDLE;
            end
            S_START: begin
                if (w_bit_done) w_state_nxt = S_DATA;
                else            w_state_nxt = S_START;
            end
            S_DATA: begin
                if (w_bit_done && (r_bit == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (w_bit_done) w_state_nxt = S_STOP;
                else            w_state_nxt = S_PARITY;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_STOP: begin
                // Chain straight into the next frame when more data is queued.
                if (w_bit_done) w_state_nxt = w_empty ? S_IDLE : S_START;
                else            w_state_nxt = S_STOP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: FIFO pop, baud/bit counters, shift register and the next txd level.
    always_comb begin
        w_pop       = 1'b0;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_txd_nxt   = 1'b1;

        // A frame is loaded from IDLE or at the end of a stop bit.
        if ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_done)) begin
            w_pop = ~w_empty;
        end else begin
            w_pop = 1'b0;
        end

        if (r_state == S_IDLE) begin
            w_baud_nxt = w_pop ? DIV_M1 : {BW{1'b0}};
        end else if (w_bit_done) begin
            w_baud_nxt = DIV_M1;
        end else begin
            w_baud_nxt = r_baud - BW'(1);
        end

        if (w_pop) begin
            w_shreg_nxt = w_head;
            w_bit_nxt   = 3'd0;
        end else if ((r_state == S_DATA) && w_bit_done) begin
            w_shreg_nxt = {1'b0, r_shreg[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
        end else begin
            w_shreg_nxt = r_shreg;
            w_bit_nxt   = r_bit;
        end

        // txd is registered, so its next value follows the next state.
        case (w_state_nxt)
            S_IDLE:   w_txd_nxt = 1'b1;
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txd_nxt = r_par;
`else
            S_PARITY: w_txd_nxt = 1'b1;
`endif
            S_STOP:   w_txd_nxt = 1'b1;
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    // Shifter datapath registers and the glitch-free txd flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud  <= {BW{1'b0}};
            r_bit   <= 3'd0;
            r_shreg <= 8'h00;
            r_txd   <= 1'b1;
        end else begin
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the frame being sent, captured when the byte is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_pop) begin
            r_par <= even_parity(w_head);
        end
    end
`endif

    // Status word assembly.
    always_comb begin
        w_status           = 32'h0000_0000;
        w_status[ST_BUSY]  = (r_state != S_IDLE);
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_OVR]   = r_ovr;
`ifdef UART_TX_PARITY_EN
        w_status[ST_PAR]   = 1'b1;
`else
        w_status[ST_PAR]   = 1'b0;
`endif
        w_status[ST_COUNT_LSB +: 16] = 16'(w_count);
    end

    // Sticky overrun (set wins over the clear-on-read) and the registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr   <= 1'b0;
            r_rdata <= 32'h0000_0000;
        end else begin
            if (w_wr_data && w_full) begin
                r_ovr <= 1'b1;
            end else if (w_rd_stat) begin
                r_ovr <= 1'b0;
            end
            if (w_rd_any) begin
                r_rdata <= w_rd_stat ? w_status : 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx (DIV=10, FIFO_DEPTH=4).
// Expected frames and status words come from a timing model: each accepted
// byte starts at max(push_edge+1, previous_start+FRAME); a write is accepted
// when fewer than DEPTH accepted bytes are still waiting at that edge.
// A line monitor decodes txd bit-times independently of the RTL.
module tb_io_uart_tx;

    localparam int DEPTH = 4;
    localparam int DIV   = 10;
`ifdef UART_TX_PARITY_EN
    localparam int   NBITS = 11;
    localparam logic PAR   = 1'b1;
`else
    localparam int   NBITS = 10;
    localparam logic PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * DIV;
    localparam logic [31:0] A_DATA  = 32'h0040_0008;
    localparam logic [31:0] A_STAT  = 32'h0040_0010;
    localparam logic [31:0] A_OTHER = 32'h0040_0004;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] io_rdata;
    logic        txd;

    io_uart_tx #(
        .CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH),
        .DATA_BIT(1), .STATUS_BIT(2)
    ) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .io_rdata(io_rdata), .txd(txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct { logic [7:0] b; int push; int start; } mexp_t;
    typedef struct { logic [7:0] b; int start; bit ok; } rx_t;

    mexp_t m_q[$];
    rx_t   rx_q[$];
    int    chk_idx = 0;
    bit    m_ovr = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;

    // ---------------- line monitor ----------------
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    int         mon_start = 0;
    logic       samp [0:FRAME-1];
    logic [7:0] mon_b;
    bit         mon_ok;

    always @(negedge clk) begin
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (txd === 1'b0) begin
                mon_act   = 1'b1;
                mon_start = edge_n;
                samp[0]   = txd;
                mon_cnt   = 1;
            end
        end else begin
            samp[mon_cnt] = txd;
            mon_cnt++;
            if (mon_cnt == FRAME) begin
                mon_ok = 1'b1;
                for (int j = 0; j < NBITS; j++)
                    for (int k = 0; k < DIV; k++)
                        if (samp[j*DIV+k] !== samp[j*DIV]) mon_ok = 1'b0;
                for (int j = 0; j < 8; j++) mon_b[j] = samp[(j+1)*DIV];
                if (samp[0] !== 1'b0) mon_ok = 1'b0;
                if (samp[(NBITS-1)*DIV] !== 1'b1) mon_ok = 1'b0;
`ifdef UART_TX_PARITY_EN
                if (samp[9*DIV] !== ^mon_b) mon_ok = 1'b0;
`endif
                rx_q.push_back('{mon_b, mon_start, mon_ok});
                mon_act = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    // Bytes waiting in the FIFO during the cycle that ends at edge e.
    function automatic int fifo_level(input int e);
        int n = 0;
        foreach (m_q[i]) if (m_q[i].push <= e-1 && m_q[i].start > e-1) n++;
        return n;
    endfunction

    function automatic logic [31:0] model_status(input int e);
        int lvl = fifo_level(e);
        logic [31:0] s;
        bit busy = 1'b0;
        foreach (m_q[i]) if (m_q[i].start <= e-1 && e-1 < m_q[i].start + FRAME) busy = 1'b1;
        s = 32'(lvl) << 16;
        s[4] = PAR;
        s[3] = m_ovr;
        s[2] = (lvl == 0);
        s[1] = (lvl == DEPTH);
        s[0] = busy;
        return s;
    endfunction

    task automatic model_write(input logic [7:0] b, input int e);
        int st;
        if (fifo_level(e) < DEPTH) begin
            st = e + 1;
            if (m_q.size() > 0 && m_q[$].start + FRAME > st) st = m_q[$].start + FRAME;
            m_q.push_back('{b, e, st});
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus cycle; called and returns at 1 time unit after a rising edge.
    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm, input logic rs);
        mem_addr = a; mem_wdata = wd; mem_wmask = wm; mem_rstrb = rs;
        @(posedge clk); #1;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_wmask = 4'h0; mem_rstrb = 1'b0;
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        int e = edge_n + 1;
        bus(A_DATA, {8'hDE, 8'hAD, 8'hBE, b}, 4'hF, 1'b0);
        model_write(b, e);
    endtask

    task automatic read_status(input string tag);
        int e = edge_n + 1;
        logic [31:0] exp = model_status(e);
        m_ovr = 1'b0;
        bus(A_STAT, 32'h0, 4'h0, 1'b1);
        check(tag, io_rdata, exp);
    endtask

    // Wait for all modelled frames to finish, then compare them with the monitor.
    task automatic check_frames(input string tag);
        int target;
        int guard = 0;
        rx_t r;
        if (m_q.size() > chk_idx) target = m_q[$].start + FRAME + 2;
        else                      target = edge_n + 2 * FRAME;
        while (edge_n < target && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_nframes"}, 32'(rx_q.size()), 32'(m_q.size() - chk_idx));
        while (rx_q.size() > 0 && chk_idx < m_q.size()) begin
            r = rx_q.pop_front();
            check({tag, "_byte"},  {24'h0, r.b}, {24'h0, m_q[chk_idx].b});
            check({tag, "_start"}, 32'(r.start), 32'(m_q[chk_idx].start));
            check({tag, "_shape"}, {31'h0, r.ok}, 32'h1);
            chk_idx++;
        end
        rx_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e;
        logic [31:0] exp;
        int s1;

        rst = 1'b1;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_wmask = 4'h0; mem_rstrb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", {31'h0, txd}, 32'h1);
        check("reset_rdata", io_rdata, 32'h0);
        rst = 1'b0;
        idle(2);

        // Read latency and hold; non-status reads return 0; non-IO write ignored.
        bus(A_OTHER, 32'h0, 4'h0, 1'b1);
        check("rd_other", io_rdata, 32'h0);
        e = edge_n + 1;
        exp = model_status(e);
        m_ovr = 1'b0;
        mem_addr = A_STAT; mem_rstrb = 1'b1;
        @(negedge clk);
        check("lat_before_edge", io_rdata, 32'h0);
        @(posedge clk); #1;
        mem_addr = 32'h0; mem_rstrb = 1'b0;
        check("lat_after_edge", io_rdata, exp);
        idle(5);
        check("lat_hold", io_rdata, exp);
        bus(A_DATA, 32'h0, 4'h0, 1'b1);
        check("rd_data_reg", io_rdata, 32'h0);
        bus(32'h0000_0008, 32'h0000_0055, 4'hF, 1'b0);
        check_frames("non_io_write");
        read_status("non_io_status");

        // Single frame 0xA5, busy mid-frame and idle afterwards.
        write_byte(8'hA5);
        idle(40);
        read_status("busy_mid_frame");
        check_frames("frame_a5");
        read_status("idle_after_a5");

        // Back-to-back frames.
        write_byte(8'h01);
        write_byte(8'h02);
        s1 = m_q[$-1].start;
        check_frames("back_to_back");
        check("b2b_gap", 32'(m_q[$].start - s1), 32'(FRAME));

        // Overrun: six consecutive writes into a depth-4 FIFO.
        for (int i = 0; i < 6; i++) write_byte(8'($urandom));
        read_status("overrun_set");
        check("overrun_bit", {31'h0, io_rdata[3]}, 32'h1);
        check("full_bit", {31'h0, io_rdata[1]}, 32'h1);
        read_status("overrun_cleared");
        check_frames("overrun_frames");

        // Randomized traffic with random gaps and status polls.
        for (int i = 0; i < 14; i++) begin
            write_byte(8'($urandom));
            idle(int'($urandom_range(0, FRAME + 20)));
            if ($urandom_range(0, 1) == 1) read_status("rnd_status");
        end
        check_frames("random");
        read_status("random_end_status");

        // Reset in the middle of the data bits of 0x3C.
        write_byte(8'h3C);
        idle(35);
        rst = 1'b1;
        #1;
        check("rst_mid_txd", {31'h0, txd}, 32'h1);
        check("rst_mid_rdata", io_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_q.delete();
        chk_idx = 0;
        m_ovr = 1'b0;
        rx_q.delete();
        idle(1);
        read_status("rst_status");
        check("rst_status_empty_only", io_rdata, {27'h0, PAR, 4'h4});
        check_frames("rst_no_resume");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
